alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised, handshaked successor to the single-cycle datapath ALU. It adds unsigned multiply (low/high), unsigned divide/remainder, logical shifts, NOR and unsigned compare, and registers every result behind a valid/ready interface. It sits in the EX stage of the multicycle CPU, where the controller stalls on `in_ready_o`/`out_valid_o`. Single-cycle ops finish in one clock. MUL/DIV ops iterate for WIDTH clocks.

## Interface
- `WIDTH`, 32: operand/result width; must be even and ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; do not override).
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `in_valid_i` input 1: operation request valid.
- `in_ready_o` output 1: block can accept a request (IDLE).
- `src1_i` input WIDTH: operand A (rs).
- `src2_i` input WIDTH: operand B (rt/imm).
- `shmat_i` input SHW: immediate shift amount.
- `ctrl_i` input 4: opcode.
- `out_valid_o` output 1: `result_o`/`zero_o` valid.
- `out_ready_i` input 1: consumer takes the result.
- `result_o` output WIDTH: registered result.
- `zero_o` output 1: `result_o == 0`, registered alongside `result_o`.
- `busy_o` output 1: high in BUSY (MUL/DIV iterating).

## Operation
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0100 NOR.
  - 0111 SLT: signed; result 1/0.
  - 0101 SLTU: unsigned; result 1/0.
  - 0011 LUI: `{src2[WIDTH/2-1:0], zeros}`.
  - 1000 SRA: `src2 >>> shmat`. 1001 SRAV: `src2 >>> src1[SHW-1:0]`.
  - 1010 SLL: `src2 << shmat`. 1011 SRL: `src2 >> shmat`.
  - 1100 MULLU: low WIDTH bits of `src1*src2`, unsigned. 1101 MULHU: high WIDTH bits.
  - 1110 DIVU: `src1/src2`. 1111 REMU: `src1%src2`.
- Add/sub wrap modulo 2^WIDTH. No overflow flag.
- Divide by zero: DIVU returns all ones; REMU returns `src1`.
- Operands and opcode are latched at accept. Later input changes have no effect.
- FSM, one-hot or encoded:
  - IDLE: `in_ready_o=1`. On `in_valid_i`:
    - single-cycle op: compute, go to DONE.
    - MUL/DIV op: load the iterator, go to BUSY.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIV) step per clock. The counter runs WIDTH-1 down to 0. When it reaches 0, write the selected half/quotient/remainder and go to DONE.
  - DONE: `out_valid_o=1`; result held stable. On `out_ready_i`, go to IDLE.
- One operation in flight. A request in BUSY/DONE is not accepted (`in_ready_o=0`); the requester holds it.
- Reset: state IDLE, `result_o=0`, `zero_o=1`, `out_valid_o=0`, `busy_o=0`, `in_ready_o=1`, counter 0. Reset in BUSY or DONE aborts the operation; no result is produced.

## Timing
- Accept happens on an edge with `in_valid_i && in_ready_o`.
- Single-cycle op: `out_valid_o` rises 1 clock after accept.
- MUL/DIV: `busy_o` high for exactly WIDTH clocks; `out_valid_o` rises WIDTH+1 clocks after accept.
- Result handoff occurs on the edge with `out_valid_o && out_ready_i`. `in_ready_o` rises the following cycle, so back-to-back single-cycle throughput is one op per 2 clocks.
- If `out_ready_i` is held high, DONE lasts exactly 1 cycle.
- `in_ready_o`, `out_valid_o` and `busy_o` decode from registered state only; there are no combinational input-to-output paths.

## Structure
- Package `alu_pkg`:
  - opcode localparams (`ALU_AND` … `ALU_REMU`);
  - FSM state typedef `alu_state_t` {IDLE, BUSY, DONE}.
- Sub-module `alu_iter_muldiv`:
  - holds the WIDTH-step shift-add multiplier / restoring divider with its accumulator (2·WIDTH), operand registers and counter;
  - interface: `start`, `is_div`, operands, `done`, `hi`/`lo` results.
- The top holds the FSM, the single-cycle combinational mux, and the output registers.

## Test plan
- Reset mid-op: start MULLU, assert `rst_i` at BUSY cycle 5 → next cycle IDLE, `out_valid_o=0`, `result_o=0`, `zero_o=1`. A following ADD 2+3 then returns 5.
- Single-cycle sweep, WIDTH=32:
  - SUB 5-7 → 0xFFFFFFFE.
  - SLT 0xFFFFFFFF,1 → 1.
  - SLTU same operands → 0.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - LUI 0x1234 → 0x12340000.
  - Each result valid 1 clock after accept.
- Multiply: MULLU and MULHU on 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001 and 0xFFFFFFFE. `busy_o` high exactly 32 clocks; valid at clock 33.
- Divide: DIVU 100/7 → 14; REMU 100/7 → 2. Divide-by-zero: DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- Backpressure: hold `out_ready_i=0` for 10 cycles after an ADD and present a new request.
  - Result and `zero_o` stay stable; `in_ready_o=0`; the new request is not accepted.
  - Release `out_ready_i` → the request is accepted the cycle after handoff.
- Zero flag and parameter: SUB 3-3 → `zero_o=1`. Rerun the multiply/divide scenarios at WIDTH=16; latency is 17.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and decode helpers for the multicycle ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_LUI   = 4'b0011;
    localparam logic [3:0] ALU_NOR   = 4'b0100;
    localparam logic [3:0] ALU_SLTU  = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_SRAV  = 4'b1001;
    localparam logic [3:0] ALU_SLL   = 4'b1010;
    localparam logic [3:0] ALU_SRL   = 4'b1011;
    localparam logic [3:0] ALU_MULLU = 4'b1100;
    localparam logic [3:0] ALU_MULHU = 4'b1101;
    localparam logic [3:0] ALU_DIVU  = 4'b1110;
    localparam logic [3:0] ALU_REMU  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // MUL/DIV family occupies the 11xx opcode quadrant.
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

    // Within 11xx, bit 1 selects divide over multiply.
    function automatic logic is_div(input logic [3:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the EX-stage controller and the multicycle ALU.
interface alu_multicycle_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [SHW-1:0]   shmat_i;
    logic [3:0]       ctrl_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             busy_o;

    // Requester side (controller).
    modport master (
        output in_valid_i, src1_i, src2_i, shmat_i, ctrl_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, zero_o, busy_o
    );

    // ALU side.
    modport slave (
        input  in_valid_i, src1_i, src2_i, shmat_i, ctrl_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, zero_o, busy_o
    );
endinterface

// File: rtl/alu_iter_muldiv.sv
// WIDTH-step unsigned shift-add multiplier / restoring divider.
// Accumulator holds {hi, lo}: product for MUL, {remainder, quotient} for DIV.
module alu_iter_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               div_q, div_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               active_q, active_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem;
    logic [WIDTH:0]     div_diff;

    // One iteration of the selected algorithm on the current accumulator.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
        // Shifted partial remainder needs WIDTH+1 bits so the MSB is not lost.
        div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_rem - {1'b0, b_q};
        if (div_q) begin
            if (!div_diff[WIDTH]) begin
                acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Load on start, then step once per clock with the counter running down to 0.
    always_comb begin
        acc_d    = acc_q;
        b_d      = b_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start_i) begin
            acc_d    = {{WIDTH{1'b0}}, op_a_i};
            b_d      = op_b_i;
            div_d    = is_div_i;
            cnt_d    = CW'(WIDTH - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            acc_d = acc_step;
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Iterator state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            b_q      <= '0;
            div_q    <= 1'b0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            b_q      <= b_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    // Results reflect the final step so the caller can capture them on the same edge.
    assign done_o = active_q && (cnt_q == '0);
    assign hi_o   = acc_step[2*WIDTH-1:WIDTH];
    assign lo_o   = acc_step[WIDTH-1:0];

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked EX-stage ALU: single-cycle ops complete in one clock, MUL/DIV iterate WIDTH clocks.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    alu_multicycle_if.slave bus
);
    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             sel_hi_q, sel_hi_d;

    logic [WIDTH-1:0] a, b;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_res;
    logic             iter_start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    assign a  = bus.src1_i;
    assign b  = bus.src2_i;
    assign sh = bus.shmat_i;

    // Single-cycle result mux; MUL/DIV opcodes are served by the iterator.
    always_comb begin
        alu_res = '0;
        case (bus.ctrl_i)
            ALU_AND:  alu_res = a & b;
            ALU_OR:   alu_res = a | b;
            ALU_ADD:  alu_res = a + b;
            ALU_SUB:  alu_res = a - b;
            ALU_NOR:  alu_res = ~(a | b);
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_LUI:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            ALU_SRA:  alu_res = $unsigned($signed(b) >>> sh);
            ALU_SRAV: alu_res = $unsigned($signed(b) >>> a[SHW-1:0]);
            ALU_SLL:  alu_res = b << sh;
            ALU_SRL:  alu_res = b >> sh;
            default:  alu_res = '0;
        endcase
    end

    assign iter_start = (state_q == IDLE) && bus.in_valid_i && is_muldiv(bus.ctrl_i);

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (iter_start),
        .is_div_i (is_div(bus.ctrl_i)),
        .op_a_i   (a),
        .op_b_i   (b),
        .done_o   (iter_done),
        .hi_o     (iter_hi),
        .lo_o     (iter_lo)
    );

    // FSM next state and result capture.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        sel_hi_d = sel_hi_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    if (is_muldiv(bus.ctrl_i)) begin
                        // MULHU and REMU both take the upper half; MULLU and DIVU the lower.
                        sel_hi_d = bus.ctrl_i[0];
                        state_d  = BUSY;
                    end else begin
                        result_d = alu_res;
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                if (iter_done) begin
                    result_d = sel_hi_q ? iter_hi : iter_lo;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            sel_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            sel_hi_q <= sel_hi_d;
        end
    end

    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.busy_o      = (state_q == BUSY);
    assign bus.result_o    = result_q;
    assign bus.zero_o      = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32 and WIDTH=16.
module tb_alu_multicycle;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(32)) b32 ();
    alu_multicycle_if #(.WIDTH(16)) b16 ();

    alu_multicycle #(.WIDTH(32)) u_dut32 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b32)
    );

    alu_multicycle #(.WIDTH(16)) u_dut16 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit w16, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic v);
        if (w16) begin
            b16.in_valid_i = v;
            b16.ctrl_i     = c;
            b16.src1_i     = a[15:0];
            b16.src2_i     = b[15:0];
            b16.shmat_i    = sh[3:0];
        end else begin
            b32.in_valid_i = v;
            b32.ctrl_i     = c;
            b32.src1_i     = a;
            b32.src2_i     = b;
            b32.shmat_i    = sh;
        end
    endtask

    // {in_ready, out_valid, busy, zero}
    function automatic logic [3:0] flags(input bit w16);
        if (w16) return {b16.in_ready_o, b16.out_valid_o, b16.busy_o, b16.zero_o};
        return {b32.in_ready_o, b32.out_valid_o, b32.busy_o, b32.zero_o};
    endfunction

    function automatic logic [31:0] res(input bit w16);
        if (w16) return {16'h0, b16.result_o};
        return b32.result_o;
    endfunction

    // Issue one op with out_ready held high; check latency, busy time, result, zero, handoff.
    task automatic do_op(input bit w16, input string tag, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] exp, input int exp_lat);
        int lat;
        int nbusy;
        b32.out_ready_i = 1'b1;
        b16.out_ready_i = 1'b1;
        drive(w16, c, a, b, sh, 1'b1);
        @(posedge clk); #1;
        // Scramble inputs after accept; the latched operands must be used.
        drive(w16, ~c, ~a, ~b, ~sh, 1'b0);
        lat   = 1;
        nbusy = 0;
        while (!flags(w16)[2] && lat < 100) begin
            if (flags(w16)[1]) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy"}, 64'(nbusy), 64'(exp_lat - 1));
        check({tag, "_res"}, 64'(res(w16)), 64'(exp));
        check({tag, "_zero"}, 64'(flags(w16)[0]), 64'(exp == 32'h0));
        @(posedge clk); #1;
        check({tag, "_handoff"}, 64'(flags(w16)[3:2]), 64'(2'b10));
    endtask

    initial begin
        drive(1'b0, 4'h0, 32'h0, 32'h0, 5'h0, 1'b0);
        drive(1'b1, 4'h0, 32'h0, 32'h0, 5'h0, 1'b0);
        b32.out_ready_i = 1'b1;
        b16.out_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst32_flags", 64'(flags(1'b0)), 64'(4'b1001));
        check("rst32_res", 64'(res(1'b0)), 64'h0);
        check("rst16_flags", 64'(flags(1'b1)), 64'(4'b1001));

        // Reset during BUSY cycle 5 aborts the multiply.
        drive(1'b0, 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 4'h0, 32'h0, 32'h0, 5'h0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        check("midop_busy", 64'(flags(1'b0)[1]), 64'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midop_flags", 64'(flags(1'b0)), 64'(4'b1001));
        check("midop_res", 64'(res(1'b0)), 64'h0);
        repeat (40) begin
            @(posedge clk); #1;
            if (flags(1'b0)[2]) check("midop_ghost", 64'(flags(1'b0)[2]), 64'h0);
        end
        do_op(1'b0, "add_after_rst", 4'b0010, 32'd2, 32'd3, 5'd0, 32'd5, 1);

        // Single-cycle sweep.
        do_op(1'b0, "sub",    4'b0110, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, 1);
        do_op(1'b0, "slt",    4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1);
        do_op(1'b0, "sltu",   4'b0101, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1);
        do_op(1'b0, "sra",    4'b1000, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1);
        do_op(1'b0, "lui",    4'b0011, 32'h0, 32'h0000_1234, 5'd0, 32'h1234_0000, 1);
        do_op(1'b0, "and",    4'b0000, 32'hF0F0, 32'hFF00, 5'd0, 32'h0000_F000, 1);
        do_op(1'b0, "or",     4'b0001, 32'hF0F0, 32'hFF00, 5'd0, 32'h0000_FFF0, 1);
        do_op(1'b0, "nor",    4'b0100, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1);
        do_op(1'b0, "sll",    4'b1010, 32'h0, 32'd1, 5'd31, 32'h8000_0000, 1);
        do_op(1'b0, "srl",    4'b1011, 32'h0, 32'h8000_0000, 5'd31, 32'd1, 1);
        do_op(1'b0, "srav",   4'b1001, 32'd8, 32'h8000_0000, 5'd0, 32'hFF80_0000, 1);
        do_op(1'b0, "addwrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0, 1);
        do_op(1'b0, "sub0",   4'b0110, 32'd3, 32'd3, 5'd0, 32'h0, 1);

        // Multiply / divide, WIDTH=32.
        do_op(1'b0, "mullu32", 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h1, 33);
        do_op(1'b0, "mulhu32", 4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFE, 33);
        do_op(1'b0, "mulhu32b", 4'b1101, 32'h1_0000, 32'h1_0000, 5'd0, 32'h1, 33);
        do_op(1'b0, "divu32",  4'b1110, 32'd100, 32'd7, 5'd0, 32'd14, 33);
        do_op(1'b0, "remu32",  4'b1111, 32'd100, 32'd7, 5'd0, 32'd2, 33);
        do_op(1'b0, "divz32",  4'b1110, 32'd9, 32'd0, 5'd0, 32'hFFFF_FFFF, 33);
        do_op(1'b0, "remz32",  4'b1111, 32'd9, 32'd0, 5'd0, 32'd9, 33);

        // Multiply / divide, WIDTH=16.
        do_op(1'b1, "mullu16", 4'b1100, 32'hFFFF, 32'hFFFF, 5'd0, 32'h0001, 17);
        do_op(1'b1, "mulhu16", 4'b1101, 32'hFFFF, 32'hFFFF, 5'd0, 32'hFFFE, 17);
        do_op(1'b1, "divu16",  4'b1110, 32'd100, 32'd7, 5'd0, 32'd14, 17);
        do_op(1'b1, "remu16",  4'b1111, 32'd100, 32'd7, 5'd0, 32'd2, 17);
        do_op(1'b1, "divz16",  4'b1110, 32'd9, 32'd0, 5'd0, 32'hFFFF, 17);
        do_op(1'b1, "remz16",  4'b1111, 32'd9, 32'd0, 5'd0, 32'd9, 17);

        // Backpressure: result held, new request waits until after handoff.
        b32.out_ready_i = 1'b0;
        drive(1'b0, 4'b0010, 32'h10, 32'h20, 5'd0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 4'b0110, 32'd9, 32'd4, 5'd0, 1'b1);
        repeat (10) begin
            check("bp_flags", 64'(flags(1'b0)), 64'(4'b0100));
            check("bp_res", 64'(res(1'b0)), 64'h30);
            @(posedge clk); #1;
        end
        b32.out_ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp_handoff", 64'(flags(1'b0)[3:2]), 64'(2'b10));
        @(posedge clk); #1;
        drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        check("bp_next_valid", 64'(flags(1'b0)[2]), 64'h1);
        check("bp_next_res", 64'(res(1'b0)), 64'd5);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
